// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the hps_io sector-channel arbiter.
// rr_pick implements the round-robin search used to choose the next drive.
package sd_arb_pkg;

  localparam int LBA_W   = 32;
  localparam int MAX_DRV = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_XFER,
    ST_FINISH
  } arb_state_t;

  // Rotate req so that bit 'start' lands at 0, priority-encode, then rotate back.
  // Returns -1 when no bit within the low n bits is set.
  function automatic int rr_pick(input logic [MAX_DRV-1:0] req, input int start, input int n);
    logic [MAX_DRV-1:0] rot;
    int pick;
    rot = '0;
    for (int k = 0; k < MAX_DRV; k++) begin
      for (int j = 0; j < MAX_DRV; j++) begin
        if (k < n && j < n && (j == start + k || j == start + k - n)) begin
          rot[k] = req[j];
        end
      end
    end
    pick = -1;
    for (int k = MAX_DRV - 1; k >= 0; k--) begin
      if (rot[k]) pick = k;
    end
    if (pick >= 0) begin
      pick = pick + start;
      if (pick >= n) pick = pick - n;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sd_req_capture.sv
// Per-drive request capture: rising-edge detect on the read/write request
// lines, a single pending bit per direction and the LBA latched on the edge.
module sd_req_capture
  import sd_arb_pkg::*;
(
  input  logic             clk_sys,
  input  logic             areset,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [LBA_W-1:0] req_lba,
  input  logic             img_mounted,
  input  logic             clr_rd,
  input  logic             clr_wr,
  output logic             pend_rd,
  output logic             pend_wr,
  output logic [LBA_W-1:0] lba_q
);

  logic old_rd;
  logic old_wr;
  logic rd_edge;
  logic wr_edge;

  assign rd_edge = req_rd & ~old_rd;
  assign wr_edge = req_wr & ~old_wr;

  // A mount change discards everything queued for this drive, including a
  // request edge in the same cycle. A new edge beats a grant-clear so a
  // request raised while the previous one is being granted is not lost.
  always_ff @(posedge clk_sys) begin
    if (areset) begin
      old_rd  <= 1'b0;
      old_wr  <= 1'b0;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      lba_q   <= '0;
    end else begin
      old_rd <= req_rd;
      old_wr <= req_wr;
      if (img_mounted) begin
        pend_rd <= 1'b0;
        pend_wr <= 1'b0;
      end else begin
        if (rd_edge) begin
          pend_rd <= 1'b1;
        end else if (clr_rd) begin
          pend_rd <= 1'b0;
        end
        if (wr_edge) begin
          pend_wr <= 1'b1;
        end else if (clr_wr) begin
          pend_wr <= 1'b0;
        end
        if (rd_edge || wr_edge) begin
          lba_q <= req_lba;
        end
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the single hps_io sector channel between NDRV
// drive requesters; reports per-drive completion and timeout/abort errors.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NDRV        = 3,
  parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000
) (
  input  logic                  clk_sys,
  input  logic                  areset,
  input  logic [NDRV-1:0]       req_rd,
  input  logic [NDRV-1:0]       req_wr,
  input  logic [32*NDRV-1:0]    req_lba,
  input  logic [NDRV-1:0]       img_mounted,
  input  logic                  sd_ack,
  output logic [31:0]           sd_lba,
  output logic [NDRV-1:0]       sd_rd,
  output logic [NDRV-1:0]       sd_wr,
  output logic                  busy,
  output logic [NDRV-1:0]       done,
  output logic [NDRV-1:0]       err,
  output logic [NDRV-1:0]       active
);

  localparam int CW = (NDRV > 1) ? $clog2(NDRV) : 1;

  logic [NDRV-1:0]    pend_rd;
  logic [NDRV-1:0]    pend_wr;
  logic [LBA_W-1:0]   lba_q [NDRV];
  logic [NDRV-1:0]    clr_rd;
  logic [NDRV-1:0]    clr_wr;

  arb_state_t         state, state_n;
  logic [CW-1:0]      cur, cur_n;
  logic [CW-1:0]      rr, rr_n;
  logic               dir_rd, dir_rd_n;
  logic               err_f, err_f_n;
  logic [23:0]        cnt, cnt_n;
  logic [LBA_W-1:0]   lba_r, lba_n;
  logic [NDRV-1:0]    rd_r, rd_n;
  logic [NDRV-1:0]    wr_r, wr_n;
  logic               old_ack;

  logic [NDRV-1:0]    cur_oh;
  logic               mount_cur;
  logic               ack_fall;
  logic [MAX_DRV-1:0] req_v;
  int                 pick;

  for (genvar g = 0; g < NDRV; g++) begin : g_cap
    sd_req_capture u_cap (
      .clk_sys     (clk_sys),
      .areset      (areset),
      .req_rd      (req_rd[g]),
      .req_wr      (req_wr[g]),
      .req_lba     (req_lba[g*LBA_W +: LBA_W]),
      .img_mounted (img_mounted[g]),
      .clr_rd      (clr_rd[g]),
      .clr_wr      (clr_wr[g]),
      .pend_rd     (pend_rd[g]),
      .pend_wr     (pend_wr[g]),
      .lba_q       (lba_q[g])
    );
  end

  assign cur_oh    = NDRV'(1) << cur;
  assign mount_cur = |(img_mounted & cur_oh);
  assign ack_fall  = old_ack & ~sd_ack;

  // Drives being unmounted this cycle are not eligible for a grant.
  always_comb begin
    req_v = '0;
    req_v[NDRV-1:0] = (pend_rd | pend_wr) & ~img_mounted;
  end

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      state   <= ST_IDLE;
      cur     <= '0;
      rr      <= '0;
      dir_rd  <= 1'b0;
      err_f   <= 1'b0;
      cnt     <= '0;
      lba_r   <= '0;
      rd_r    <= '0;
      wr_r    <= '0;
      old_ack <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      rr      <= rr_n;
      dir_rd  <= dir_rd_n;
      err_f   <= err_f_n;
      cnt     <= cnt_n;
      lba_r   <= lba_n;
      rd_r    <= rd_n;
      wr_r    <= wr_n;
      old_ack <= sd_ack;
    end
  end

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    rr_n     = rr;
    dir_rd_n = dir_rd;
    err_f_n  = err_f;
    cnt_n    = cnt;
    lba_n    = lba_r;
    rd_n     = rd_r;
    wr_n     = wr_r;
    clr_rd   = '0;
    clr_wr   = '0;
    pick     = rr_pick(req_v, int'(rr), NDRV);

    case (state)
      ST_IDLE: begin
        if (pick >= 0) begin
          for (int i = 0; i < NDRV; i++) begin
            if (pick == i) begin
              cur_n    = CW'(i);
              dir_rd_n = pend_rd[i];
              lba_n    = lba_q[i];
              if (pend_rd[i]) begin
                clr_rd[i] = 1'b1;
              end else begin
                clr_wr[i] = 1'b1;
              end
            end
          end
          state_n = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_n = '0;
        if (mount_cur) begin
          err_f_n = 1'b1;
          state_n = ST_FINISH;
        end else begin
          rd_n    = dir_rd ? cur_oh : '0;
          wr_n    = dir_rd ? '0 : cur_oh;
          state_n = ST_WAIT_ACK;
        end
      end

      // An ack arriving on the last allowed cycle still wins over the timeout.
      ST_WAIT_ACK: begin
        if (mount_cur) begin
          rd_n    = '0;
          wr_n    = '0;
          err_f_n = 1'b1;
          state_n = ST_FINISH;
        end else if (sd_ack) begin
          rd_n    = '0;
          wr_n    = '0;
          state_n = ST_XFER;
        end else if (cnt == ACK_TIMEOUT - 24'd1) begin
          rd_n    = '0;
          wr_n    = '0;
          err_f_n = 1'b1;
          state_n = ST_FINISH;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end

      ST_XFER: begin
        if (ack_fall) begin
          state_n = ST_FINISH;
        end
      end

      ST_FINISH: begin
        rr_n    = (int'(cur) == NDRV - 1) ? '0 : cur + 1'b1;
        err_f_n = 1'b0;
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign sd_lba = lba_r;
  assign sd_rd  = rd_r;
  assign sd_wr  = wr_r;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FINISH) ? cur_oh : '0;
  assign err    = (state == ST_FINISH && err_f) ? cur_oh : '0;
  assign active = busy ? cur_oh : '0;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: a table of single transactions plus
// hand-written sequences for round-robin, aborts, timeouts and reset.
module tb_sd_req_arbiter;

  localparam int NDRV = 3;

  logic        clk_sys = 1'b0;
  logic        areset;
  logic [2:0]  req_rd;
  logic [2:0]  req_wr;
  logic [95:0] req_lba;
  logic [2:0]  img_mounted;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic [2:0]  sd_rd;
  logic [2:0]  sd_wr;
  logic        busy;
  logic [2:0]  done;
  logic [2:0]  err;
  logic [2:0]  active;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  vec;
    bit          rd;
    logic [31:0] lba;
    int          ack_at;
    int          hold;
    int          exp_len;
    logic [2:0]  exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];

  always #5 clk_sys = ~clk_sys;

  sd_req_arbiter #(
    .NDRV        (NDRV),
    .ACK_TIMEOUT (24'd16)
  ) dut (
    .clk_sys     (clk_sys),
    .areset      (areset),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba     (req_lba),
    .img_mounted (img_mounted),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .active      (active)
  );

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] rd, input logic [2:0] wr,
                                input logic [2:0] mnt, input logic [95:0] lbas);
    req_lba     = lbas;
    req_rd      = rd;
    req_wr      = wr;
    img_mounted = mnt;
    @(negedge clk_sys);
    req_rd      = '0;
    req_wr      = '0;
    img_mounted = '0;
  endtask

  task automatic do_reset(input string tag);
    areset = 1'b1;
    @(negedge clk_sys);
    areset = 1'b0;
    check_output({tag, "/sd_rd"},  sd_rd,  0);
    check_output({tag, "/sd_wr"},  sd_wr,  0);
    check_output({tag, "/sd_lba"}, sd_lba, 0);
    check_output({tag, "/busy"},   busy,   0);
    check_output({tag, "/done"},   done,   0);
    check_output({tag, "/err"},    err,    0);
    check_output({tag, "/active"}, active, 0);
  endtask

  task automatic wait_strobe(input string tag, output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_sys);
      lat++;
      if ((sd_rd | sd_wr) != 3'b000) begin
        got = 1'b1;
        break;
      end
    end
    check_output({tag, "/strobe_seen"}, got, 1);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk_sys);
      if (busy || done != 3'b000 || (sd_rd | sd_wr) != 3'b000) seen = 1'b1;
    end
    check_output({tag, "/stays_idle"}, seen, 0);
  endtask

  // inj_kind: 0 none, 1 read request on inj_drv, 2 mount pulse on inj_drv (during XFER)
  task automatic serve(input string tag, input logic [2:0] vec, input bit rd,
                       input logic [31:0] lba, input int ack_at, input int hold,
                       input int exp_len, input logic [2:0] exp_err, input int exp_lat,
                       input int inj_kind, input int inj_drv, input logic [31:0] inj_lba);
    bit got;
    int lat;
    int len;
    wait_strobe(tag, got, lat);
    if (!got) return;
    if (exp_lat >= 0) check_output({tag, "/latency"}, lat, exp_lat);
    check_output({tag, "/sd_rd"},  sd_rd,  rd ? vec : 3'b000);
    check_output({tag, "/sd_wr"},  sd_wr,  rd ? 3'b000 : vec);
    check_output({tag, "/sd_lba"}, sd_lba, lba);
    check_output({tag, "/active"}, active, vec);
    check_output({tag, "/busy"},   busy,   1);
    len = 1;
    if (ack_at == 1) sd_ack = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_sys);
      if ((sd_rd | sd_wr) == 3'b000) break;
      len++;
      if (len == ack_at) sd_ack = 1'b1;
    end
    check_output({tag, "/strobe_len"}, len, exp_len);
    if (ack_at < 0) begin
      check_output({tag, "/done"}, done, vec);
      check_output({tag, "/err"},  err,  exp_err);
    end else begin
      check_output({tag, "/xfer_done"}, done, 0);
      for (int k = 0; k < hold - 1; k++) begin
        if (k == 0 && inj_kind == 1) begin
          req_lba[inj_drv*32 +: 32] = inj_lba;
          req_rd[inj_drv] = 1'b1;
        end
        if (k == 0 && inj_kind == 2) img_mounted[inj_drv] = 1'b1;
        if (k == 1) begin
          req_rd      = '0;
          img_mounted = '0;
        end
        @(negedge clk_sys);
      end
      check_output({tag, "/xfer_lba"},    sd_lba, lba);
      check_output({tag, "/xfer_strobe"}, sd_rd | sd_wr, 0);
      check_output({tag, "/xfer_busy"},   busy, 1);
      sd_ack = 1'b0;
      @(negedge clk_sys);
      check_output({tag, "/done"}, done, vec);
      check_output({tag, "/err"},  err,  exp_err);
    end
    @(negedge clk_sys);
    check_output({tag, "/done_pulse"}, {err, done}, 0);
  endtask

  initial begin
    logic [95:0] lbas;
    bit          got;
    int          lat;

    areset      = 1'b1;
    req_rd      = '0;
    req_wr      = '0;
    req_lba     = '0;
    img_mounted = '0;
    sd_ack      = 1'b0;

    tbl[0] = '{3'b001, 1'b1, 32'h0000_0010,  4, 512,  4, 3'b000, 2};
    tbl[1] = '{3'b010, 1'b0, 32'hABCD_0001,  1,   4,  1, 3'b000, 2};
    tbl[2] = '{3'b100, 1'b1, 32'hFFFF_FFFF,  7,   3,  7, 3'b000, 2};
    tbl[3] = '{3'b001, 1'b0, 32'h8000_0000, -1,   0, 16, 3'b001, 2};
    tbl[4] = '{3'b100, 1'b0, 32'h1234_5678, 16,   5, 16, 3'b000, 2};

    @(negedge clk_sys);
    do_reset("reset");

    for (int i = 0; i < 5; i++) begin
      lbas = '0;
      for (int j = 0; j < NDRV; j++) begin
        if (tbl[i].vec[j]) lbas[j*32 +: 32] = tbl[i].lba;
      end
      apply_stimulus(tbl[i].rd ? tbl[i].vec : 3'b000, tbl[i].rd ? 3'b000 : tbl[i].vec, 3'b000, lbas);
      serve($sformatf("row%0d", i), tbl[i].vec, tbl[i].rd, tbl[i].lba, tbl[i].ack_at,
            tbl[i].hold, tbl[i].exp_len, tbl[i].exp_err, tbl[i].exp_lat, 0, 0, 32'h0);
    end

    $display("[TB] round-robin");
    do_reset("rr_reset");
    apply_stimulus(3'b101, 3'b010, 3'b000, {32'h102, 32'h101, 32'h100});
    serve("rr_d0", 3'b001, 1'b1, 32'h100, 2, 4, 2, 3'b000, 2, 0, 0, 32'h0);
    serve("rr_d1", 3'b010, 1'b0, 32'h101, 2, 4, 2, 3'b000, -1, 0, 0, 32'h0);
    serve("rr_d2", 3'b100, 1'b1, 32'h102, 3, 6, 3, 3'b000, -1, 1, 0, 32'h200);
    serve("rr_d0b", 3'b001, 1'b1, 32'h200, 2, 4, 2, 3'b000, -1, 0, 0, 32'h0);

    $display("[TB] same drive rd+wr");
    apply_stimulus(3'b010, 3'b010, 3'b000, {32'h0, 32'h5, 32'h0});
    serve("rw_rd", 3'b010, 1'b1, 32'h5, 2, 4, 2, 3'b000, 2, 0, 0, 32'h0);
    serve("rw_wr", 3'b010, 1'b0, 32'h5, 2, 4, 2, 3'b000, -1, 0, 0, 32'h0);

    $display("[TB] timeout then next request");
    apply_stimulus(3'b001, 3'b000, 3'b000, {32'h0, 32'h0, 32'h40});
    apply_stimulus(3'b000, 3'b100, 3'b000, {32'h42, 32'h0, 32'h0});
    serve("to_d0", 3'b001, 1'b1, 32'h40, -1, 0, 16, 3'b001, -1, 0, 0, 32'h0);
    serve("to_d2", 3'b100, 1'b0, 32'h42, 2, 4, 2, 3'b000, -1, 0, 0, 32'h0);

    $display("[TB] unmount abort");
    apply_stimulus(3'b010, 3'b000, 3'b000, {32'h0, 32'h55, 32'h0});
    wait_strobe("ab", got, lat);
    check_output("ab/sd_rd", sd_rd, 3'b010);
    @(negedge clk_sys);
    img_mounted = 3'b010;
    @(negedge clk_sys);
    img_mounted = 3'b000;
    check_output("ab/strobe_drop", sd_rd | sd_wr, 0);
    check_output("ab/done", done, 3'b010);
    check_output("ab/err",  err,  3'b010);
    @(negedge clk_sys);
    check_output("ab/done_pulse", {err, done}, 0);
    apply_stimulus(3'b010, 3'b000, 3'b000, {32'h0, 32'h56, 32'h0});
    serve("ab_xfer", 3'b010, 1'b1, 32'h56, 2, 6, 2, 3'b000, 2, 2, 1, 32'h0);
    apply_stimulus(3'b100, 3'b000, 3'b100, {32'h99, 32'h0, 32'h0});
    watch_idle("mount_vs_req", 8);

    $display("[TB] reset mid-transfer");
    apply_stimulus(3'b001, 3'b100, 3'b000, {32'h78, 32'h0, 32'h77});
    wait_strobe("rst", got, lat);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check_output("rst/xfer_strobe", sd_rd | sd_wr, 0);
    check_output("rst/xfer_busy", busy, 1);
    sd_ack = 1'b0;
    do_reset("rst_mid");
    watch_idle("rst_after", 8);
    apply_stimulus(3'b110, 3'b000, 3'b000, {32'h92, 32'h91, 32'h0});
    serve("rst_d1", 3'b010, 1'b1, 32'h91, 2, 4, 2, 3'b000, 2, 0, 0, 32'h0);
    serve("rst_d2", 3'b100, 1'b1, 32'h92, 2, 4, 2, 3'b000, -1, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares the single hps_io virtual-disk sector channel (sd_lba / sd_rd / sd_wr / sd_ack) between NDRV drive requesters (D1, D2, cartridge loader).
- Captures per-drive block read/write requests, serves one at a time in round-robin order and drives the one-hot sd_rd/sd_wr vectors and sd_lba.
- Reports per-drive completion and timeout errors back to the ZPU-side status logic.
- Sits between the ZPU I/O decode and hps_io in the emu top level.

Parameters:
- NDRV, 3, number of requesters and the width of the sd_rd/sd_wr vectors.
- ACK_TIMEOUT, 24'd10_000_000, clk_sys cycles to wait for sd_ack to rise before aborting.

Ports:
- clk_sys  in  1  system clock
- areset  in  1  synchronous, active-high reset
- req_rd  in  NDRV  per-drive read request; rising edge is captured
- req_wr  in  NDRV  per-drive write request; rising edge is captured
- req_lba  in  32*NDRV  per-drive LBA, sampled on the request edge
- img_mounted  in  NDRV  mount/unmount pulse from hps_io
- sd_ack  in  1  hps_io transfer acknowledge
- sd_lba  out  32  LBA of the active request
- sd_rd  out  NDRV  one-hot read strobe to hps_io
- sd_wr  out  NDRV  one-hot write strobe to hps_io
- busy  out  1  a request is in service
- done  out  NDRV  one-cycle completion pulse, per drive
- err  out  NDRV  one-cycle pulse issued with done on timeout or abort
- active  out  NDRV  one-hot drive currently granted

Behaviour:
- Reset (areset, synchronous): all outputs go to 0, sd_lba=0, all pending bits cleared, rr pointer=0, state=IDLE. Reset mid-transfer drops sd_rd/sd_wr on the next edge with no done pulse.
- Capture:
  - Edge detect against registered req_rd/req_wr. A rising edge on drive i sets pend_rd[i] or pend_wr[i] and latches lba_q[i]=req_lba[i] on the same edge.
  - A new edge for a drive that already has a pending request of the same kind overwrites lba_q and keeps a single pending entry.
  - Rising rd and wr edges in the same cycle for the same drive: both pend bits are set; read is served first.
- States: IDLE, ISSUE, WAIT_ACK, XFER, FINISH.
- IDLE:
  - Search starts at the rr pointer and wraps modulo NDRV. The first drive with pend_rd|pend_wr wins.
  - Latch cur=i and dir (read if pend_rd[i], else write). Clear that pend bit and set sd_lba=lba_q[i]. Go to ISSUE.
  - With no pending request, stay in IDLE.
- ISSUE: assert sd_rd[cur] or sd_wr[cur] (exactly one bit of the 2*NDRV). Clear the timeout counter. Go to WAIT_ACK.
- WAIT_ACK:
  - Strobe held; counter increments each cycle.
  - sd_ack=1: drop the strobe the same edge and go to XFER.
  - Counter reaches ACK_TIMEOUT-1: drop the strobe, set err_f, go to FINISH.
- XFER:
  - sd_lba is held stable and strobes stay 0.
  - sd_ack falling (registered old_ack=1, sd_ack=0) → FINISH.
  - No timeout applies in XFER.
- FINISH: pulse done[cur] for exactly one cycle, and err[cur] too if err_f. Advance rr=(cur+1) mod NDRV. Clear err_f. Go to IDLE.
- Strobe timing: first strobe cycle is 2 cycles after the request edge (capture, IDLE, ISSUE). Strobe-to-done latency after the sd_ack fall is 1 cycle.
- img_mounted[i] pulse:
  - Clears pend_rd[i] and pend_wr[i].
  - If cur==i in ISSUE or WAIT_ACK: drop the strobe, set err_f, go to FINISH.
  - In XFER the transfer completes normally.
  - A mount pulse coincident with a request edge: the mount wins and the request is discarded.
- busy=1 in every state except IDLE. active[cur]=1 while busy.
- sd_ack already high on entry to WAIT_ACK (stale) is treated as a valid ack.

Decomposition:
- Package sd_arb_pkg: state enum typedef (arb_state_t), LBA width constant (32), and a rr_pick function (rotate, priority encode, rotate back).
- Sub-module sd_req_capture: per-drive edge detect, pending bits, LBA latch and mount clear. One instance per drive via generate.

Test Plan:
1. Single read: req_rd[0]↑ with req_lba[31:0]=0x0000_0010; hps_io model acks 3 cycles after the strobe, holds for 512 cycles → sd_rd=3'b001 for 4 cycles, sd_lba=0x10, done[0] pulses 1 cycle after the ack falls, err=0.
2. Round-robin: req_rd[0]↑, req_wr[1]↑, req_rd[2]↑ in the same cycle, rr=0 → service order 0(rd), 1(wr), 2(rd), each with the correct LBA. A second req_rd[0]↑ raised during drive 2's XFER is served next.
3. Same-drive rd+wr: req_rd[1]↑ and req_wr[1]↑ simultaneously, LBAs 5 → read LBA 5 served first, then write LBA 5; two done[1] pulses.
4. Timeout: ACK_TIMEOUT=16, sd_ack never asserted → strobe high for 16 cycles then drops; done[0] and err[0] pulse together; next pending request proceeds.
5. Unmount abort: img_mounted[1] pulse during WAIT_ACK for drive 1 → strobe drops next cycle, done[1]+err[1]. The same pulse during XFER → no abort, normal done[1] with err=0.
6. Reset mid-XFER: areset=1 for one cycle → all outputs 0, pending cleared, no done pulse; a fresh request afterwards is served with rr=0.
